// File: rtl/uart_rx.sv
// uart_rx: UART receiver with centre sampling, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with a parity_err strobe
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = 217
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [8:0] BIT_END  = 9'(CLKS_PER_BIT - 1);
  localparam logic [8:0] HALF_END = 9'(HALF_BIT - 1);
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic rx_m, rx_s, rx_q;
  logic [8:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shreg, shreg_n, data_n;
  logic done_n, ferr_n, par_ok, tick;
`ifdef UART_RX_PARITY_EN
  logic par, par_n, perr_n;
  assign par_ok = ~^{shreg, par};
`else
  assign par_ok = 1'b1;
`endif
  assign tick    = cnt == BIT_END;
  assign rx_busy = state != IDLE;
  // two-flop synchronizer plus one delay flop for falling-edge detection
  always_ff @(posedge clk_50M or posedge rst)
    if (rst) {rx_m, rx_s, rx_q} <= 3'b111;
    else {rx_m, rx_s, rx_q} <= {rx, rx_m, rx_s};
  // state, counters, shift register and registered outputs
  always_ff @(posedge clk_50M or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par        <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      data      <= data_n;
      rx_done   <= done_n;
      frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par        <= par_n;
      parity_err <= perr_n;
`endif
    end
  // next state, bit-centre sampling and strobe decisions
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 9'd1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    data_n    = data;
    done_n    = 1'b0;
    ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n  = par;
    perr_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_q && !rx_s) state_n = START;
      end
      START: if (cnt == HALF_END) begin
        cnt_n     = '0;
        bit_idx_n = '0;
        state_n   = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_n            = '0;
        shreg_n[bit_idx] = rx_s;
        bit_idx_n        = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = AFTER_DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        cnt_n   = '0;
        par_n   = rx_s;
        state_n = STOP;
      end
`endif
      STOP: if (tick) begin
        cnt_n   = '0;
        state_n = IDLE;
        ferr_n  = !rx_s;
        done_n  = rx_s && par_ok;
        data_n  = done_n ? shreg : data;
`ifdef UART_RX_PARITY_EN
        perr_n  = rx_s && !par_ok;
`endif
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level scoreboard
module tb_uart_rx;
  localparam int C = 434;
  localparam int H = 217;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  logic clk_50M = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] data;
  logic rx_done, rx_busy, frame_err, parity_err;
  int checks = 0, failures = 0, cyc = 0, overlap = 0;
  int ev_kind[$], ev_cyc[$], exp_kind[$], exp_cyc[$];
  logic [7:0] ev_data[$], exp_data[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLKS_PER_BIT(C), .HALF_BIT(H)) dut (
    .clk_50M(clk_50M), .rst(rst), .rx(rx), .data(data), .rx_done(rx_done),
    .rx_busy(rx_busy), .frame_err(frame_err)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #10 clk_50M = ~clk_50M;
  always @(posedge clk_50M) cyc <= cyc + 1;

  // strobe monitor: kind 1 = byte received, 2 = framing error, 3 = parity error
  always @(negedge clk_50M)
    if (!rst) begin
      if (rx_done)    begin ev_kind.push_back(1); ev_data.push_back(data); ev_cyc.push_back(cyc); end
      if (frame_err)  begin ev_kind.push_back(2); ev_data.push_back(data); ev_cyc.push_back(cyc); end
      if (parity_err) begin ev_kind.push_back(3); ev_data.push_back(data); ev_cyc.push_back(cyc); end
      if (rx_done && frame_err) overlap <= overlap + 1;
    end

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  task automatic clear_q();
    ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
    exp_kind.delete(); exp_data.delete(); exp_cyc.delete();
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  // drives one frame and records what a correct receiver must report for it
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic p);
    int start, kind;
    start = cyc;
    drive(1'b0, C);
    for (int i = 0; i < 8; i++) drive(b[i], C);
    if (PAR != 0) drive(p, C);
    drive(stop, C);
    kind = !stop ? 2 : (PAR != 0 && (^{b, p})) ? 3 : 1;
    if (kind == 1) last_good = b;
    exp_kind.push_back(kind);
    exp_data.push_back(last_good);
    exp_cyc.push_back(start + 2 + H + (9 + PAR) * C + 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_50M);
    #1;
    checks++;
    if ({data, rx_done, rx_busy, frame_err, parity_err} !== 12'h000) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=000", {data, rx_done, rx_busy, frame_err, parity_err});
    end
    rst = 1'b0;
    repeat (5) @(posedge clk_50M);
    #1;
    checks++;
    if ({data, rx_done, rx_busy, frame_err, parity_err} !== 12'h000) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=000", {data, rx_done, rx_busy, frame_err, parity_err});
    end
  endtask

  task automatic test_single();
    clear_q();
    send_frame(8'h55, 1'b1, even_par(8'h55));
    drive(1'b1, 5);
    checks++;
    if (ev_kind.size() != exp_kind.size()) begin
      failures++;
      $display("FAIL single_count got=%0d exp=%0d", ev_kind.size(), exp_kind.size());
    end
    foreach (exp_kind[i]) if (i < ev_kind.size()) begin
      checks++;
      if (ev_kind[i] != exp_kind[i] || ev_data[i] !== exp_data[i] || ev_cyc[i] < exp_cyc[i] - 1 || ev_cyc[i] > exp_cyc[i] + 1) begin
        failures++;
        $display("FAIL single_ev%0d got kind=%0d data=%h cyc=%0d exp kind=%0d data=%h cyc=%0d", i, ev_kind[i], ev_data[i], ev_cyc[i], exp_kind[i], exp_data[i], exp_cyc[i]);
      end
    end
    checks++;
    if (data !== 8'h55 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL single_data got=%h/%b exp=55/0", data, frame_err);
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(8'hA5, 1'b1, even_par(8'hA5));
    send_frame(8'h3C, 1'b1, even_par(8'h3C));
    drive(1'b1, 5);
    checks++;
    if (ev_kind.size() != exp_kind.size()) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=%0d", ev_kind.size(), exp_kind.size());
    end
    foreach (exp_kind[i]) if (i < ev_kind.size()) begin
      checks++;
      if (ev_kind[i] != exp_kind[i] || ev_data[i] !== exp_data[i] || ev_cyc[i] < exp_cyc[i] - 1 || ev_cyc[i] > exp_cyc[i] + 1) begin
        failures++;
        $display("FAIL b2b_ev%0d got kind=%0d data=%h cyc=%0d exp kind=%0d data=%h cyc=%0d", i, ev_kind[i], ev_data[i], ev_cyc[i], exp_kind[i], exp_data[i], exp_cyc[i]);
      end
    end
    if (ev_cyc.size() >= 2) begin
      checks++;
      if (ev_cyc[1] - ev_cyc[0] < (10 + PAR) * C - 1 || ev_cyc[1] - ev_cyc[0] > (10 + PAR) * C + 1) begin
        failures++;
        $display("FAIL b2b_spacing got=%0d exp=%0d", ev_cyc[1] - ev_cyc[0], (10 + PAR) * C);
      end
    end
  endtask

  task automatic test_glitch();
    int start, t;
    clear_q();
    start = cyc;
    drive(1'b0, 100);
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy got=%b exp=1", rx_busy);
    end
    rx = 1'b1;
    t = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_50M);
      if (!rx_busy) begin
        t = cyc - start;
        break;
      end
    end
    checks++;
    if (t < H || t > H + 4) begin
      failures++;
      $display("FAIL glitch_busy_fall got=%0d exp=%0d..%0d", t, H, H + 4);
    end
    drive(1'b1, C);
    checks++;
    if (ev_kind.size() != 0 || data !== last_good) begin
      failures++;
      $display("FAIL glitch_quiet got events=%0d data=%h exp events=0 data=%h", ev_kind.size(), data, last_good);
    end
  endtask

  task automatic test_frame_err();
    clear_q();
    send_frame(8'hFF, 1'b0, even_par(8'hFF));
    drive(1'b0, 10000);
    checks++;
    if (ev_kind.size() != exp_kind.size()) begin
      failures++;
      $display("FAIL ferr_count got=%0d exp=%0d", ev_kind.size(), exp_kind.size());
    end
    drive(1'b1, 2 * C);
    send_frame(8'h12, 1'b1, even_par(8'h12));
    drive(1'b1, 5);
    checks++;
    if (ev_kind.size() != exp_kind.size()) begin
      failures++;
      $display("FAIL ferr_total got=%0d exp=%0d", ev_kind.size(), exp_kind.size());
    end
    foreach (exp_kind[i]) if (i < ev_kind.size()) begin
      checks++;
      if (ev_kind[i] != exp_kind[i] || ev_data[i] !== exp_data[i] || ev_cyc[i] < exp_cyc[i] - 1 || ev_cyc[i] > exp_cyc[i] + 1) begin
        failures++;
        $display("FAIL ferr_ev%0d got kind=%0d data=%h cyc=%0d exp kind=%0d data=%h cyc=%0d", i, ev_kind[i], ev_data[i], ev_cyc[i], exp_kind[i], exp_data[i], exp_cyc[i]);
      end
    end
    checks++;
    if (data !== 8'h12) begin
      failures++;
      $display("FAIL ferr_recover got=%h exp=12", data);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'hF0;
    clear_q();
    drive(1'b0, C);
    for (int i = 0; i < 4; i++) drive(b[i], C);
    drive(b[4], C / 2);
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_busy got=%b exp=1", rx_busy);
    end
    rst = 1'b1;
    last_good = 8'h00;
    #1;
    checks++;
    if ({data, rx_done, rx_busy, frame_err, parity_err} !== 12'h000) begin
      failures++;
      $display("FAIL rstmid_outputs got=%h exp=000", {data, rx_done, rx_busy, frame_err, parity_err});
    end
    @(posedge clk_50M);
    #1;
    rst = 1'b0;
    drive(1'b1, 2 * C);
    clear_q();
    send_frame(8'h0F, 1'b1, even_par(8'h0F));
    drive(1'b1, 5);
    checks++;
    if (ev_kind.size() != exp_kind.size()) begin
      failures++;
      $display("FAIL rstmid_count got=%0d exp=%0d", ev_kind.size(), exp_kind.size());
    end
    foreach (exp_kind[i]) if (i < ev_kind.size()) begin
      checks++;
      if (ev_kind[i] != exp_kind[i] || ev_data[i] !== exp_data[i] || ev_cyc[i] < exp_cyc[i] - 1 || ev_cyc[i] > exp_cyc[i] + 1) begin
        failures++;
        $display("FAIL rstmid_ev%0d got kind=%0d data=%h cyc=%0d exp kind=%0d data=%h cyc=%0d", i, ev_kind[i], ev_data[i], ev_cyc[i], exp_kind[i], exp_data[i], exp_cyc[i]);
      end
    end
    checks++;
    if (data !== 8'h0F) begin
      failures++;
      $display("FAIL rstmid_data got=%h exp=0f", data);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic stop, p;
    clear_q();
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom);
      stop = $urandom_range(0, 3) != 0;
      p = even_par(b) ^ ($urandom_range(0, 3) == 0);
      send_frame(b, stop, p);
      drive(1'b1, stop ? $urandom_range(1, C) : C);
    end
    checks++;
    if (ev_kind.size() != exp_kind.size()) begin
      failures++;
      $display("FAIL random_count got=%0d exp=%0d", ev_kind.size(), exp_kind.size());
    end
    foreach (exp_kind[i]) if (i < ev_kind.size()) begin
      checks++;
      if (ev_kind[i] != exp_kind[i] || ev_data[i] !== exp_data[i] || ev_cyc[i] < exp_cyc[i] - 1 || ev_cyc[i] > exp_cyc[i] + 1) begin
        failures++;
        $display("FAIL random_ev%0d got kind=%0d data=%h cyc=%0d exp kind=%0d data=%h cyc=%0d", i, ev_kind[i], ev_data[i], ev_cyc[i], exp_kind[i], exp_data[i], exp_cyc[i]);
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_q();
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b0, 1'b0);
    drive(1'b1, C);
    checks++;
    if (ev_kind.size() != 3) begin
      failures++;
      $display("FAIL parity_count got=%0d exp=3", ev_kind.size());
    end
    foreach (exp_kind[i]) if (i < ev_kind.size()) begin
      checks++;
      if (ev_kind[i] != exp_kind[i] || ev_data[i] !== exp_data[i] || ev_cyc[i] < exp_cyc[i] - 1 || ev_cyc[i] > exp_cyc[i] + 1) begin
        failures++;
        $display("FAIL parity_ev%0d got kind=%0d data=%h cyc=%0d exp kind=%0d data=%h cyc=%0d", i, ev_kind[i], ev_data[i], ev_cyc[i], exp_kind[i], exp_data[i], exp_cyc[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (overlap != 0) begin
      failures++;
      $display("FAIL strobe_overlap got=%0d exp=0", overlap);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
